// File: rtl/snake_tick_scheduler.sv
// rtl/snake_tick_scheduler.sv - game-phase sequencer, move tick scheduler and direction arbiter
module snake_tick_scheduler #(
  parameter int BASE_PERIOD    = 8,
  parameter int MIN_PERIOD     = 2,
  parameter int SPEED_SHIFT    = 2,
  parameter int RESTART_FRAMES = 2,
  parameter int PERIOD_W       = 4
) (
  input  logic                vga_clock,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                up_in,
  input  logic                down_in,
  input  logic                left_in,
  input  logic                right_in,
  input  logic                start_btn,
  input  logic                dead_in,
  input  logic [9:0]          length_in,
  output logic                move_tick,
  output logic [1:0]          direction,
  output logic                restart_out,
  output logic [1:0]          state,
  output logic [PERIOD_W-1:0] period
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_DEAD    = 2'd2,
    S_RESTART = 2'd3
  } state_e;

  localparam logic signed [10:0] BASE_S = 11'(BASE_PERIOD);
  localparam logic signed [10:0] MIN_S  = 11'(MIN_PERIOD);

  state_e              state_q, state_d;
  logic                move_tick_q, move_tick_d;
  logic [1:0]          dir_q, dir_d;
  logic [1:0]          pend_q, pend_d;
  logic                restart_q, restart_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                start_prev_q, start_prev_d;

  logic                start_press;
  logic [PERIOD_W:0]   cnt_inc;
  logic [9:0]          len_shift;
  logic signed [10:0]  raw_period;
  logic [PERIOD_W-1:0] next_period;
  logic                cand_valid;
  logic [1:0]          cand;

  assign start_press  = start_btn & ~start_prev_q;
  assign start_prev_d = start_btn;
  assign cnt_inc      = {1'b0, frame_cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign len_shift    = length_in >> SPEED_SHIFT;
  assign raw_period   = BASE_S - $signed({1'b0, len_shift});
  assign next_period  = (raw_period < MIN_S) ? PERIOD_W'(MIN_PERIOD) : raw_period[PERIOD_W-1:0];

  // Fixed priority up > down > left > right
  always_comb begin
    cand_valid = 1'b1;
    cand       = 2'd3;
    if (up_in)         cand = 2'd0;
    else if (down_in)  cand = 2'd1;
    else if (left_in)  cand = 2'd2;
    else if (right_in) cand = 2'd3;
    else               cand_valid = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    move_tick_d = 1'b0;
    dir_d       = dir_q;
    pend_d      = pend_q;
    restart_d   = restart_q;
    period_d    = period_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE, S_DEAD: begin
        frame_cnt_d = '0;
        if (start_press) begin
          state_d   = S_RESTART;
          restart_d = 1'b1;
        end
      end
      S_RESTART: begin
        if (frame_start) begin
          if (cnt_inc == (PERIOD_W+1)'(RESTART_FRAMES)) begin
            state_d     = S_PLAY;
            restart_d   = 1'b0;
            dir_d       = 2'd3;
            pend_d      = 2'd3;
            frame_cnt_d = '0;
            period_d    = PERIOD_W'(BASE_PERIOD);
          end else begin
            frame_cnt_d = cnt_inc[PERIOD_W-1:0];
          end
        end
      end
      S_PLAY: begin
        // Opposite directions differ only in bit 0
        if (cand_valid && (cand != (dir_q ^ 2'd1))) pend_d = cand;
        if (dead_in) begin
          state_d     = S_DEAD;
          frame_cnt_d = '0;
        end else if (frame_start) begin
          if (cnt_inc == {1'b0, period_q}) begin
            move_tick_d = 1'b1;
            frame_cnt_d = '0;
            dir_d       = pend_d;
            period_d    = next_period;
          end else begin
            frame_cnt_d = cnt_inc[PERIOD_W-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      move_tick_q  <= 1'b0;
      dir_q        <= 2'd3;
      pend_q       <= 2'd3;
      restart_q    <= 1'b0;
      period_q     <= PERIOD_W'(BASE_PERIOD);
      frame_cnt_q  <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_tick_q  <= move_tick_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      restart_q    <= restart_d;
      period_q     <= period_d;
      frame_cnt_q  <= frame_cnt_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign move_tick   = move_tick_q;
  assign direction   = dir_q;
  assign restart_out = restart_q;
  assign state       = state_q;
  assign period      = period_q;

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// tb/tb_snake_tick_scheduler.sv - randomized bench for snake_tick_scheduler with behavioural model
module tb_snake_tick_scheduler;

  localparam int BASE = 8;
  localparam int MINP = 2;
  localparam int SHIFT = 2;
  localparam int RFR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       up_in = 1'b0, down_in = 1'b0, left_in = 1'b0, right_in = 1'b0;
  logic       start_btn = 1'b0;
  logic       dead_in = 1'b0;
  logic [9:0] length_in = 10'd1;
  logic       move_tick;
  logic [1:0] direction;
  logic       restart_out;
  logic [1:0] state;
  logic [3:0] period;

  always #5 clk = ~clk;

  snake_tick_scheduler dut (
    .vga_clock   (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .up_in       (up_in),
    .down_in     (down_in),
    .left_in     (left_in),
    .right_in    (right_in),
    .start_btn   (start_btn),
    .dead_in     (dead_in),
    .length_in   (length_in),
    .move_tick   (move_tick),
    .direction   (direction),
    .restart_out (restart_out),
    .state       (state),
    .period      (period)
  );

  int n_tests = 0;
  int n_fail = 0;
  int tick_count = 0;

  // Reference model: game phase, frames since last event, move interval, headings
  int m_state = 0, m_frames = 0, m_period = BASE, m_dir = 3, m_pend = 3;
  int m_tick = 0, m_restart = 0, m_prev_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_step();
    int press;
    int btn[4];
    if (reset) begin
      m_state = 0; m_frames = 0; m_period = BASE; m_dir = 3; m_pend = 3;
      m_tick = 0; m_restart = 0; m_prev_start = 0;
      return;
    end
    press = (start_btn && !m_prev_start) ? 1 : 0;
    m_prev_start = int'(start_btn);
    m_tick = 0;
    btn[0] = int'(up_in); btn[1] = int'(down_in); btn[2] = int'(left_in); btn[3] = int'(right_in);
    case (m_state)
      0, 2: begin
        m_frames = 0;
        if (press) begin m_state = 3; m_restart = 1; end
      end
      3: if (frame_start) begin
        m_frames++;
        if (m_frames == RFR) begin
          m_state = 1; m_restart = 0; m_dir = 3; m_pend = 3; m_frames = 0; m_period = BASE;
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          if (btn[i]) begin
            if (i != opposite(m_dir)) m_pend = i;
            break;
          end
        end
        if (dead_in) begin
          m_state = 2; m_frames = 0;
        end else if (frame_start) begin
          m_frames++;
          if (m_frames == m_period) begin
            m_tick = 1; m_frames = 0; m_dir = m_pend;
            m_period = BASE - (int'(length_in) / (1 << SHIFT));
            if (m_period < MINP) m_period = MINP;
          end
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (move_tick === 1'b1) tick_count++;
    check("state", 32'(state), m_state);
    check("move_tick", 32'(move_tick), m_tick);
    check("direction", 32'(direction), m_dir);
    check("restart_out", 32'(restart_out), m_restart);
    check("period", 32'(period), m_period);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    cycle();
  endtask

  int t0;

  initial begin
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_tick", 32'(move_tick), 0);
    check("rst_dir", 32'(direction), 3);
    check("rst_restart", 32'(restart_out), 0);
    check("rst_period", 32'(period), BASE);

    press_start();
    check("restart_hi", 32'(restart_out), 1);
    frame();
    check("restart_hold", 32'(restart_out), 1);
    frame();
    check("play_state", 32'(state), 1);
    check("play_dir", 32'(direction), 3);
    check("play_period", 32'(period), 8);

    length_in = 10'd1;
    t0 = tick_count;
    repeat (24) frame();
    check("ticks_24_frames", 32'(tick_count - t0), 3);

    length_in = 10'd40;
    repeat (8) frame();
    check("period_sat", 32'(period), 2);
    length_in = 10'd12;
    repeat (2) frame();
    check("period_len12", 32'(period), 5);

    left_in = 1'b1;
    repeat (5) frame();
    left_in = 1'b0;
    check("reverse_rejected", 32'(direction), 3);
    up_in = 1'b1; cycle(); up_in = 1'b0;
    repeat (5) frame();
    check("turn_up", 32'(direction), 0);
    right_in = 1'b1; cycle(); right_in = 1'b0;
    repeat (5) frame();
    check("turn_right", 32'(direction), 3);
    up_in = 1'b1; right_in = 1'b1; cycle(); up_in = 1'b0; right_in = 1'b0;
    repeat (5) frame();
    check("up_beats_right", 32'(direction), 0);

    repeat (4) frame();
    t0 = tick_count;
    dead_in = 1'b1; frame_start = 1'b1;
    cycle();
    dead_in = 1'b0; frame_start = 1'b0;
    cycle();
    check("death_no_tick", 32'(tick_count - t0), 0);
    check("dead_state", 32'(state), 2);
    press_start();
    check("dead_to_restart", 32'(state), 3);

    frame();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("midrst_state", 32'(state), 0);
    check("midrst_restart", 32'(restart_out), 0);
    press_start();
    frame();
    check("midrst_cnt_cleared", 32'(state), 3);
    frame();
    check("midrst_replay", 32'(state), 1);

    for (int i = 0; i < 6000; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      up_in    = ($urandom_range(0, 7) == 0);
      down_in  = ($urandom_range(0, 7) == 0);
      left_in  = ($urandom_range(0, 7) == 0);
      right_in = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      dead_in  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) length_in = 10'($urandom_range(0, 1023));
      reset    = ($urandom_range(0, 799) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
